regfile_port_arb: RTL
=====================

# regfile_port_arb

Two-requester arbiter in front of the 32×32 register file (r0 hard-wired to zero; one write port, two combinational read ports, synchronous write on `clk`, write enable `L_S`). The arbiter accepts at most one transaction per cycle from two independent valid/ready requesters, such as a fetch/decode unit and a debug/load unit. It drives the register file's address, data and write-enable pins and returns read data through a one-deep registered response slot per requester, with backpressure.

## Interface
- `FIXED_PRIO`, default 0: 0 selects round-robin arbitration; 1 makes requester 0 always win.
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: register address width.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `reqN_valid` in 1 (N = 0, 1): transaction offered.
- `reqN_ready` out 1: transaction accepted this cycle.
- `reqN_we` in 1: 1 = write, 0 = read-pair.
- `reqN_addr_a` in ADDR_W: read address A, or the write address when `reqN_we` = 1.
- `reqN_addr_b` in ADDR_W: read address B; ignored on writes.
- `reqN_wdata` in DATA_W: write data.
- `rspN_valid` out 1: read response held.
- `rspN_ready` in 1: response consumed.
- `rspN_data_a`, `rspN_data_b` out DATA_W: read results.
- `rf_addr_a`, `rf_addr_b`, `rf_waddr` out ADDR_W: register-file addresses.
- `rf_wdata` out DATA_W: register-file write data.
- `rf_we` out 1: connects to the register file's `L_S`.
- `rf_rdata_a`, `rf_rdata_b` in DATA_W: combinational read data from the register file.

## Operation
**Per-requester state**
- Each requester has a response slot: `rspN_valid` flag plus two data registers.
- A global `last` pointer (1 bit) records the most recently granted requester.

**Eligibility**
- Requester N is eligible when `reqN_valid` = 1 and either:
  - it is a write, or
  - it is a read and slot N is empty or drains this cycle (`rspN_valid` & `rspN_ready`).

**Grant**
- If exactly one requester is eligible, it is granted.
- If both are eligible:
  - with `FIXED_PRIO` = 1, requester 0 is granted;
  - otherwise, the requester ≠ `last` is granted.
- `reqN_ready` = grant N. It is combinational, so `reqN_valid` must not depend on `reqN_ready`.
- `last` updates only on a grant.

**Granted write**
- `rf_waddr` = `addr_a`, `rf_wdata` = `wdata`.
- `rf_we` = 1 unless `addr_a` = 0. A write to r0 completes the handshake but is dropped.
- No response is produced.

**Granted read**
- `rf_addr_a`/`rf_addr_b` = request addresses, with `rf_we` = 0.
- At the edge, `rf_rdata_a`/`rf_rdata_b` load into slot N and `rspN_valid` is set.

**Slot update rules**
- Slot N clears on `rspN_valid` & `rspN_ready` when no new read fills it in the same cycle.
- Simultaneous drain and fill leaves `rspN_valid` = 1 with the new data.

**Idle and ungranted cycles**
- With no grant, `rf_we` = 0 and the `rf_*` address/data outputs are 0.

## Timing
- **Reset values:** all `rspN_valid`/`rspN_data` = 0, `last` = 1 (requester 0 wins the first tie), `rf_we` = 0, `reqN_ready` = 0.
- **Read latency:** accept at edge k, so `rspN_valid` = 1 from cycle k+1 with data as of the start of cycle k.
- **Write visibility:** a write accepted at edge k is visible to any read accepted in cycle k+1 or later. No bypass is needed, since only one transaction is accepted per cycle.
- **Throughput:** one transaction per cycle total. A requester whose `rspN_ready` is held 1 can issue back-to-back reads.
- **Backpressure:** a full, undrained slot blocks only reads from that requester. Its writes and the other requester proceed.
- **Reset mid-operation:** pending responses are discarded immediately (asynchronous clear). No register-file write occurs while `rst` = 1.

## Structure
- Package `regfile_arb_pkg` holds:
  - `ADDR_W`, `DATA_W`, and `REG_ZERO` = 5'd0;
  - a typedef for the request bundle (`we`, `addr_a`, `addr_b`, `wdata`).
- Sub-module `rr_arb2`: 2-way round-robin arbiter (eligibility in, one-hot grant out, `last` pointer inside, `FIXED_PRIO` parameter).
- The top level instantiates `rr_arb2`, the output mux, and two response slots.

## Test plan
1. **Write then read:** after reset, req0 writes r5 = 0xDEADBEEF (1 cycle), then reads (a=5, b=0). Expect `rsp0_valid` one cycle after accept, `data_a` = 0xDEADBEEF, `data_b` = 0.
2. **Write to r0:** req1 writes addr 0, data 0x1234. Expect `req1_ready` = 1 and `rf_we` = 0; a subsequent read of r0 returns 0.
3. **Round-robin:** both requesters hold reads for 6 cycles with `rspN_ready` = 1 and `FIXED_PRIO` = 0. Expect grants 0,1,0,1,0,1. With `FIXED_PRIO` = 1, expect 0,0,0,0,0,0.
4. **Backpressure:** `rsp0_ready` = 0 with `rsp0_valid` = 1. A req0 read gets `req0_ready` = 0 every cycle while a req0 write is accepted. Raising `rsp0_ready` grants the read in the same cycle, and `rsp0_valid` stays 1 with the new data.
5. **Reset mid-operation:** assert `rst` mid-cycle while `rsp1_valid` = 1. Expect `rsp1_valid` = 0 immediately and `rf_we` = 0. After release, the first tie grants req0.

Source files
------------

// File: rtl/regfile_port_arb_pkg.sv
// Shared widths, the r0 address and the request bundle type for the register-file port arbiter.
package regfile_arb_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/regfile_port_arb_rr_arb2.sv
// Two-way arbiter. It is round-robin on the last granted requester, or fixed
// priority to requester 0 when FIXED_PRIO is set.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  output logic [1:0] grant
);

  logic last;

  // A lone eligible requester wins. A tie goes to the requester that was not granted last.
  always_comb begin
    grant = elig;
    if (&elig) begin
      grant = (FIXED_PRIO || last) ? 2'b01 : 2'b10;
    end
  end

  // Remember who was granted most recently. After reset requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (|grant) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_port_arb.sv
// Arbiter that lets two valid/ready requesters share the single write port and
// the two read ports of the 32x32 register file. Each requester gets a one-deep
// registered read-response slot.
module regfile_port_arb #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned DATA_W     = regfile_arb_pkg::DATA_W,
  parameter int unsigned ADDR_W     = regfile_arb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr_a,
  input  logic [ADDR_W-1:0] req0_addr_b,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr_a,
  input  logic [ADDR_W-1:0] req1_addr_b,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data_a,
  output logic [DATA_W-1:0] rsp0_data_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data_a,
  output logic [DATA_W-1:0] rsp1_data_b,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b
);

  import regfile_arb_pkg::*;

  req_t              req [2];
  req_t              sel_req;
  logic              rsp_ready [2];
  logic              rsp_valid [2];
  logic [DATA_W-1:0] rsp_a [2];
  logic [DATA_W-1:0] rsp_b [2];
  logic [1:0]        elig;
  logic [1:0]        grant;

  assign req[0] = '{we: req0_we, addr_a: req0_addr_a, addr_b: req0_addr_b, wdata: req0_wdata};
  assign req[1] = '{we: req1_we, addr_a: req1_addr_a, addr_b: req1_addr_b, wdata: req1_wdata};
  assign rsp_ready[0] = rsp0_ready;
  assign rsp_ready[1] = rsp1_ready;

  // Writes are always eligible. A read is eligible only if its slot is free or
  // drains this cycle. Nothing is eligible while in reset, so no write can reach the file.
  assign elig[0] = ~rst & req0_valid & (req0_we | ~rsp_valid[0] | rsp_ready[0]);
  assign elig[1] = ~rst & req1_valid & (req1_we | ~rsp_valid[1] | rsp_ready[1]);

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .elig  (elig),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign sel_req    = grant[1] ? req[1] : req[0];

  // Drive the register-file pins from the granted request. All pins idle at zero otherwise.
  always_comb begin
    rf_addr_a = '0;
    rf_addr_b = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    rf_we     = 1'b0;
    if (|grant) begin
      if (sel_req.we) begin
        rf_waddr = sel_req.addr_a;
        rf_wdata = sel_req.wdata;
        rf_we    = (sel_req.addr_a != REG_ZERO);
      end else begin
        rf_addr_a = sel_req.addr_a;
        rf_addr_b = sel_req.addr_b;
      end
    end
  end

  for (genvar n = 0; n < 2; n++) begin : g_slot
    // Response slot. A new read fill takes precedence over a drain in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rsp_valid[n] <= 1'b0;
        rsp_a[n]     <= '0;
        rsp_b[n]     <= '0;
      end else if (grant[n] && !req[n].we) begin
        rsp_valid[n] <= 1'b1;
        rsp_a[n]     <= rf_rdata_a;
        rsp_b[n]     <= rf_rdata_b;
      end else if (rsp_valid[n] && rsp_ready[n]) begin
        rsp_valid[n] <= 1'b0;
      end
    end
  end

  assign rsp0_valid  = rsp_valid[0];
  assign rsp0_data_a = rsp_a[0];
  assign rsp0_data_b = rsp_b[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp1_data_a = rsp_a[1];
  assign rsp1_data_b = rsp_b[1];

endmodule
